// File: rtl/can_bit_timing_ctrl.sv
// CAN/CAN-FD bit-timing scheduler: prescales clk_in into time quanta and steps each bit
// through SYNC/TSEG1/TSEG2 with nominal/data rate switching at the sample point.
module can_bit_timing_ctrl #(
  parameter int BRP_W  = 8,
  parameter int SEG1_W = 8,
  parameter int SEG2_W = 7
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic              hard_sync,
  input  logic              rate_sel,
  input  logic [BRP_W-1:0]  brp_nom,
  input  logic [SEG1_W-1:0] tseg1_nom,
  input  logic [SEG2_W-1:0] tseg2_nom,
  input  logic [BRP_W-1:0]  brp_dat,
  input  logic [SEG1_W-1:0] tseg1_dat,
  input  logic [SEG2_W-1:0] tseg2_dat,
  output logic              tq_tick,
  output logic              bit_start,
  output logic              sample_pt,
  output logic              active_rate,
  output logic [1:0]        seg_state
);

  localparam int CNT_W = (SEG1_W > SEG2_W) ? SEG1_W : SEG2_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SYNC  = 2'b01,
    ST_TSEG1 = 2'b10,
    ST_TSEG2 = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [BRP_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]  tq_cnt_q, tq_cnt_d;
  logic [BRP_W-1:0]  brp_q, brp_d;
  logic [SEG1_W-1:0] tseg1_q, tseg1_d;
  logic [SEG2_W-1:0] tseg2_q, tseg2_d;
  logic              active_rate_q, active_rate_d;
  logic              bit_start_q, bit_start_d;

  logic [BRP_W-1:0]  brp_eff;
  logic [SEG1_W-1:0] tseg1_eff;
  logic [SEG2_W-1:0] tseg2_eff;
  logic              tick_w, last1_w, last2_w, hs_w, load_all;

  // A zero field behaves as one tq / one clock.
  assign brp_eff   = (brp_q   == '0) ? BRP_W'(1)  : brp_q;
  assign tseg1_eff = (tseg1_q == '0) ? SEG1_W'(1) : tseg1_q;
  assign tseg2_eff = (tseg2_q == '0) ? SEG2_W'(1) : tseg2_q;

  assign tick_w  = (state_q != ST_IDLE) && (pc_q == (brp_eff - BRP_W'(1)));
  assign last1_w = (tq_cnt_q == (CNT_W'(tseg1_eff) - CNT_W'(1)));
  assign last2_w = (tq_cnt_q == (CNT_W'(tseg2_eff) - CNT_W'(1)));
  assign hs_w    = enable && hard_sync && (state_q != ST_IDLE);

  assign tq_tick     = tick_w;
  assign sample_pt   = (state_q == ST_TSEG1) && tick_w && last1_w && !hs_w;
  assign bit_start   = bit_start_q;
  assign active_rate = active_rate_q;
  assign seg_state   = state_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tq_cnt_d      = tq_cnt_q;
    brp_d         = brp_q;
    tseg1_d       = tseg1_q;
    tseg2_d       = tseg2_q;
    active_rate_d = active_rate_q;
    bit_start_d   = 1'b0;
    load_all      = 1'b0;

    if (!enable) begin
      state_d       = ST_IDLE;
      pc_d          = '0;
      tq_cnt_d      = '0;
      active_rate_d = 1'b0;
    end else if (state_q == ST_IDLE || hard_sync) begin
      state_d     = ST_SYNC;
      pc_d        = '0;
      tq_cnt_d    = '0;
      bit_start_d = 1'b1;
      load_all    = 1'b1;
    end else begin
      pc_d = tick_w ? '0 : pc_q + BRP_W'(1);
      if (tick_w) begin
        case (state_q)
          ST_SYNC: begin
            state_d  = ST_TSEG1;
            tq_cnt_d = '0;
          end
          ST_TSEG1: begin
            if (last1_w) begin
              state_d       = ST_TSEG2;
              tq_cnt_d      = '0;
              active_rate_d = rate_sel;
              // A rate change takes effect immediately for this bit's TSEG2.
              if (rate_sel != active_rate_q) begin
                brp_d   = rate_sel ? brp_dat : brp_nom;
                tseg2_d = rate_sel ? tseg2_dat : tseg2_nom;
              end
            end else begin
              tq_cnt_d = tq_cnt_q + CNT_W'(1);
            end
          end
          ST_TSEG2: begin
            if (last2_w) begin
              state_d     = ST_SYNC;
              tq_cnt_d    = '0;
              bit_start_d = 1'b1;
              load_all    = 1'b1;
            end else begin
              tq_cnt_d = tq_cnt_q + CNT_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (load_all) begin
      brp_d   = active_rate_d ? brp_dat   : brp_nom;
      tseg1_d = active_rate_d ? tseg1_dat : tseg1_nom;
      tseg2_d = active_rate_d ? tseg2_dat : tseg2_nom;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      tq_cnt_q      <= '0;
      brp_q         <= '0;
      tseg1_q       <= '0;
      tseg2_q       <= '0;
      active_rate_q <= 1'b0;
      bit_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      tq_cnt_q      <= tq_cnt_d;
      brp_q         <= brp_d;
      tseg1_q       <= tseg1_d;
      tseg2_q       <= tseg2_d;
      active_rate_q <= active_rate_d;
      bit_start_q   <= bit_start_d;
    end
  end

endmodule

// File: tb/tb_can_bit_timing_ctrl.sv
// Directed bench for can_bit_timing_ctrl: table of nominal configurations plus
// hand-written rate-switch, hard-sync, disable and async-reset sequences.
module tb_can_bit_timing_ctrl;

  logic       clk_in = 1'b0;
  logic       rst, enable, hard_sync, rate_sel;
  logic [7:0] brp_nom, tseg1_nom, brp_dat, tseg1_dat;
  logic [6:0] tseg2_nom, tseg2_dat;
  logic       tq_tick, bit_start, sample_pt, active_rate;
  logic [1:0] seg_state;

  can_bit_timing_ctrl dut (
    .clk_in(clk_in), .rst(rst), .enable(enable), .hard_sync(hard_sync), .rate_sel(rate_sel),
    .brp_nom(brp_nom), .tseg1_nom(tseg1_nom), .tseg2_nom(tseg2_nom),
    .brp_dat(brp_dat), .tseg1_dat(tseg1_dat), .tseg2_dat(tseg2_dat),
    .tq_tick(tq_tick), .bit_start(bit_start), .sample_pt(sample_pt),
    .active_rate(active_rate), .seg_state(seg_state)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] brp;
    logic [7:0] t1;
    logic [6:0] t2;
    int         period;
    int         sp;
    int         tq;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // which: 0 bit_start, 1 sample_pt, 2 tq_tick; always advances at least one cycle
  task automatic wait_sig(input int which, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_in);
      if ((which == 0 && bit_start) || (which == 1 && sample_pt) || (which == 2 && tq_tick)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_sig%0d timeout after %0d cycles", which, maxc);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_tq_tick"},   int'(tq_tick),     0);
    check({name, "_bit_start"}, int'(bit_start),   0);
    check({name, "_sample_pt"}, int'(sample_pt),   0);
    check({name, "_rate"},      int'(active_rate), 0);
    check({name, "_state"},     int'(seg_state),   0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    hard_sync = 1'b0;
    @(negedge clk_in);
    check_idle("reset");
    rst = 1'b0;
  endtask

  initial begin
    int b0, b1, s, a, c, h;
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, b2, b3, s, s2, s3, a, c, h;
    vecs[0] = '{8'd4, 8'd5, 7'd2, 32, 23, 4};
    vecs[1] = '{8'd0, 8'd0, 7'd0,  3,  1, 1};
    vecs[2] = '{8'd2, 8'd3, 7'd4, 16,  7, 2};
    vecs[3] = '{8'd1, 8'd1, 7'd1,  3,  1, 1};
    vecs[4] = '{8'd3, 8'd0, 7'd0,  9,  5, 3};

    rst = 1'b1; enable = 1'b0; hard_sync = 1'b0; rate_sel = 1'b0;
    brp_dat = 8'd9; tseg1_dat = 8'd9; tseg2_dat = 7'd9;
    brp_nom = 8'd4; tseg1_nom = 8'd5; tseg2_nom = 7'd2;
    #3;

    foreach (vecs[k]) begin
      brp_nom = vecs[k].brp; tseg1_nom = vecs[k].t1; tseg2_nom = vecs[k].t2;
      rate_sel = 1'b0;
      do_reset();
      enable = 1'b1;
      wait_sig(0, 2, b0);
      check("vec_sync_state", int'(seg_state), 1);
      wait_sig(1, 600, s);
      check("vec_sample_off", s - b0, vecs[k].sp);
      wait_sig(0, 600, b1);
      check("vec_period", b1 - b0, vecs[k].period);
      wait_sig(2, 600, a);
      wait_sig(2, 600, c);
      check("vec_tq_period", c - a, vecs[k].tq);
    end

    // Rate switch to data and back
    brp_nom = 8'd4; tseg1_nom = 8'd5; tseg2_nom = 7'd2;
    brp_dat = 8'd1; tseg1_dat = 8'd3; tseg2_dat = 7'd1;
    rate_sel = 1'b0;
    do_reset();
    enable = 1'b1;
    wait_sig(0, 2, b0);
    rate_sel = 1'b1;
    wait_sig(1, 100, s);
    check("sw_nom_sample", s - b0, 23);
    @(negedge clk_in);
    check("sw_rate_after_sp", int'(active_rate), 1);
    check("sw_tseg2_state", int'(seg_state), 3);
    wait_sig(0, 100, b1);
    check("sw_bit_after_sp", b1 - s, 2);
    wait_sig(1, 100, s2);
    check("sw_dat_sample", s2 - b1, 3);
    wait_sig(0, 100, b2);
    check("sw_dat_period", b2 - b1, 5);
    check("sw_rate_held", int'(active_rate), 1);
    rate_sel = 1'b0;
    wait_sig(1, 100, s3);
    check("back_dat_sample", s3 - b2, 3);
    wait_sig(0, 100, b3);
    check("back_tseg2_len", b3 - s3, 9);
    check("back_rate", int'(active_rate), 0);
    wait_sig(1, 100, s);
    check("back_nom_sample", s - b3, 23);
    wait_sig(0, 100, b0);
    check("back_nom_period", b0 - b3, 32);

    // Hard sync mid-TSEG1
    do_reset();
    enable = 1'b1;
    wait_sig(0, 2, b0);
    repeat (10) @(negedge clk_in);
    check("hs_pre_state", int'(seg_state), 2);
    hard_sync = 1'b1;
    @(negedge clk_in);
    hard_sync = 1'b0;
    h = cyc;
    check("hs_bit_start", int'(bit_start), 1);
    check("hs_state", int'(seg_state), 1);
    wait_sig(1, 100, s);
    check("hs_next_sample", s - h, 23);
    check("hs_rate", int'(active_rate), 0);

    // Disable mid-TSEG2 while on data rate, then re-enable
    do_reset();
    enable = 1'b1;
    rate_sel = 1'b1;
    wait_sig(0, 2, b0);
    wait_sig(1, 100, s);
    wait_sig(0, 100, b1);
    repeat (4) @(negedge clk_in);
    check("dis_pre_state", int'(seg_state), 3);
    check("dis_pre_rate", int'(active_rate), 1);
    enable = 1'b0;
    @(negedge clk_in);
    check_idle("disable");
    rate_sel = 1'b0;
    enable = 1'b1;
    wait_sig(0, 1, b0);
    wait_sig(1, 100, s);
    check("reen_sample", s - b0, 23);
    wait_sig(0, 100, b1);
    check("reen_period", b1 - b0, 32);

    // Asynchronous reset mid-bit
    repeat (6) @(negedge clk_in);
    #2 rst = 1'b1;
    #1 check_idle("async_rst");
    @(negedge clk_in);
    rst = 1'b0;
    wait_sig(0, 1, b0);
    wait_sig(1, 100, s);
    check("rst_reen_sample", s - b0, 23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
